trap_detect_pipe: RTL and testbench

- Multi-lane successor to the EXE-stage trap condition detector.
- Evaluates MIPS conditional trap instructions (TEQ/TNE/TGE/TGEU/TLT/TLTU and their immediate forms) for LANES issue slots at DATA_WIDTH.
- Registers the per-lane results and selects the oldest trapping lane.
- Holds a single pending trap-exception record for CP0 under a req/ack handshake, and keeps a saturating trap count.

---
 rtl/trap_detect_pipe.sv | 101 ++++++++++
 tb/tb_trap_detect_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_detect_pipe.sv
// trap_detect_pipe: multi-lane MIPS trap detection with a registered hit/kill stage,
// a single pending CP0 exception record under req/ack, and a saturating trap count.
module trap_detect_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 2,
  parameter int PC_WIDTH   = 32,
  parameter int CNT_WIDTH  = 16,
  localparam int LW        = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic                        flush,
  input  logic [LANES-1:0]            lane_valid,
  input  logic [3*LANES-1:0]          lane_trap_op,
  input  logic [DATA_WIDTH*LANES-1:0] lane_op_a,
  input  logic [DATA_WIDTH*LANES-1:0] lane_op_b,
  input  logic [PC_WIDTH*LANES-1:0]   lane_pc,
  output logic [LANES-1:0]            trap_hit,
  output logic [LANES-1:0]            kill_mask,
  output logic                        exc_req,
  output logic [PC_WIDTH-1:0]         exc_pc,
  output logic [LW-1:0]               exc_lane,
  output logic [2:0]                  exc_op,
  input  logic                        exc_ack,
  output logic [CNT_WIDTH-1:0]        trap_cnt
);
  logic [LANES-1:0]     hit_c, kill_c, trap_hit_q, kill_mask_q;
  logic                 any_c, load;
  logic [LW-1:0]        win_lane, exc_lane_q;
  logic [PC_WIDTH-1:0]  win_pc, exc_pc_q;
  logic [2:0]           win_op, exc_op_q;
  logic                 exc_req_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Walk lanes oldest-first: kill_c[i] is the OR of hits in older lanes,
  // and the first hit seen becomes the record winner.
  always_comb begin
    hit_c    = '0;
    kill_c   = '0;
    any_c    = 1'b0;
    win_lane = '0;
    win_pc   = '0;
    win_op   = '0;
    for (int i = 0; i < LANES; i++) begin
      logic [DATA_WIDTH-1:0] a, b;
      logic [2:0]            op;
      logic                  cond;
      a    = lane_op_a[i*DATA_WIDTH +: DATA_WIDTH];
      b    = lane_op_b[i*DATA_WIDTH +: DATA_WIDTH];
      op   = lane_trap_op[3*i +: 3];
      cond = (op == 3'd1) ? (a == b) :
             (op == 3'd2) ? (a != b) :
             (op == 3'd3) ? ($signed(a) >= $signed(b)) :
             (op == 3'd4) ? (a >= b) :
             (op == 3'd5) ? ($signed(a) < $signed(b)) :
             (op == 3'd6) ? (a < b) : 1'b0;
      hit_c[i]  = lane_valid[i] & cond;
      kill_c[i] = any_c;
      if (hit_c[i] && !any_c) begin
        win_lane = LW'(i);
        win_pc   = lane_pc[i*PC_WIDTH +: PC_WIDTH];
        win_op   = op;
      end
      any_c = any_c | hit_c[i];
    end
  end

  assign load  = any_c & ~stall & ~flush & (~exc_req_q | exc_ack);
  assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap_hit_q  <= '0;
      kill_mask_q <= '0;
      exc_req_q   <= 1'b0;
      exc_pc_q    <= '0;
      exc_lane_q  <= '0;
      exc_op_q    <= '0;
      cnt_q       <= '0;
    end else begin
      trap_hit_q  <= flush ? '0 : stall ? trap_hit_q : hit_c;
      kill_mask_q <= flush ? '0 : stall ? kill_mask_q : kill_c;
      exc_req_q   <= load | (exc_req_q & ~exc_ack);
      if (load) begin
        exc_pc_q   <= win_pc;
        exc_lane_q <= win_lane;
        exc_op_q   <= win_op;
        cnt_q      <= cnt_d;
      end
    end
  end

  assign trap_hit  = trap_hit_q;
  assign kill_mask = kill_mask_q;
  assign exc_req   = exc_req_q;
  assign exc_pc    = exc_pc_q;
  assign exc_lane  = exc_lane_q;
  assign exc_op    = exc_op_q;
  assign trap_cnt  = cnt_q;
endmodule

// File: tb/tb_trap_detect_pipe.sv
// tb_trap_detect_pipe: directed checks of trap detection, record handshake, stall/flush,
// counter saturation (2-bit counter build) and asynchronous reset.
module tb_trap_detect_pipe;
  logic        clk = 1'b0;
  logic        rst, stall, flush, exc_ack;
  logic [1:0]  lane_valid;
  logic [5:0]  lane_trap_op;
  logic [63:0] lane_op_a, lane_op_b, lane_pc;
  logic [1:0]  trap_hit, kill_mask, trap_hit_s, kill_mask_s;
  logic        exc_req, exc_req_s;
  logic [31:0] exc_pc, exc_pc_s;
  logic        exc_lane, exc_lane_s;
  logic [2:0]  exc_op, exc_op_s;
  logic [15:0] trap_cnt;
  logic [1:0]  trap_cnt_s;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  trap_detect_pipe dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .lane_valid(lane_valid),
    .lane_trap_op(lane_trap_op), .lane_op_a(lane_op_a), .lane_op_b(lane_op_b), .lane_pc(lane_pc),
    .trap_hit(trap_hit), .kill_mask(kill_mask), .exc_req(exc_req), .exc_pc(exc_pc),
    .exc_lane(exc_lane), .exc_op(exc_op), .exc_ack(exc_ack), .trap_cnt(trap_cnt)
  );

  trap_detect_pipe #(.CNT_WIDTH(2)) dut_s (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .lane_valid(lane_valid),
    .lane_trap_op(lane_trap_op), .lane_op_a(lane_op_a), .lane_op_b(lane_op_b), .lane_pc(lane_pc),
    .trap_hit(trap_hit_s), .kill_mask(kill_mask_s), .exc_req(exc_req_s), .exc_pc(exc_pc_s),
    .exc_lane(exc_lane_s), .exc_op(exc_op_s), .exc_ack(exc_ack), .trap_cnt(trap_cnt_s)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic v, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
    lane_valid[i]         = v;
    lane_trap_op[3*i +: 3] = op;
    lane_op_a[32*i +: 32]  = a;
    lane_op_b[32*i +: 32]  = b;
    lane_pc[32*i +: 32]    = pc;
  endtask

  task automatic idle;
    lane_valid = '0; lane_trap_op = '0; lane_op_a = '0; lane_op_b = '0; lane_pc = '0;
    stall = 1'b0; flush = 1'b0; exc_ack = 1'b0;
  endtask

  task automatic do_reset;
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    idle();
    rst = 1'b1;
    #2;
    n_cmp++;
    if ({trap_hit, kill_mask, exc_req, exc_pc, exc_lane, exc_op, trap_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got hit=%b kill=%b req=%b pc=%h lane=%b op=%b cnt=%0d want all 0",
               trap_hit, kill_mask, exc_req, exc_pc, exc_lane, exc_op, trap_cnt);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_basic;
    do_reset();
    set_lane(0, 1, 3'd1, 32'd5, 32'd5, 32'h100);
    set_lane(1, 1, 3'd5, 32'hFFFF_FFFF, 32'd0, 32'h104);
    tick();
    n_cmp++;
    if (trap_hit !== 2'b11 || kill_mask !== 2'b10) begin
      n_fail++;
      $display("FAIL basic_hit_kill got %b/%b want 11/10", trap_hit, kill_mask);
    end
    n_cmp++;
    if (exc_req !== 1'b1 || exc_lane !== 1'b0 || exc_op !== 3'b001 || exc_pc !== 32'h100 || trap_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL basic_record got req=%b lane=%b op=%b pc=%h cnt=%0d want 1/0/001/100/1",
               exc_req, exc_lane, exc_op, exc_pc, trap_cnt);
    end
  endtask

  task automatic test_signed;
    logic [2:0] ops [5] = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic       exp [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_lane(0, 1, ops[k], 32'hFFFF_FFFF, 32'd1, 32'h200);
      set_lane(1, 0, 3'd1, 32'd7, 32'd7, 32'h204);
      tick();
      n_cmp++;
      if (trap_hit !== {1'b0, exp[k]}) begin
        n_fail++;
        $display("FAIL signed_op%0d got %b want %b", ops[k], trap_hit, {1'b0, exp[k]});
      end
    end
    set_lane(0, 0, 3'd1, 32'd7, 32'd7, 32'h200);
    set_lane(1, 1, 3'd7, 32'd7, 32'd7, 32'h204);
    tick();
    n_cmp++;
    if (trap_hit !== 2'b00) begin
      n_fail++;
      $display("FAIL reserved_or_invalid got %b want 00", trap_hit);
    end
  endtask

  task automatic test_pending;
    do_reset();
    set_lane(0, 1, 3'd2, 32'd1, 32'd2, 32'hA0);
    tick();
    n_cmp++;
    if (exc_req !== 1'b1 || exc_pc !== 32'hA0 || kill_mask !== 2'b10 || trap_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL pend_a got req=%b pc=%h kill=%b cnt=%0d want 1/a0/10/1", exc_req, exc_pc, kill_mask, trap_cnt);
    end
    set_lane(0, 0, 3'd0, 32'd0, 32'd0, 32'h0);
    set_lane(1, 1, 3'd1, 32'd3, 32'd3, 32'hB4);
    tick();
    n_cmp++;
    if (trap_hit !== 2'b10 || kill_mask !== 2'b00 || exc_pc !== 32'hA0 || exc_lane !== 1'b0 ||
        exc_op !== 3'd2 || trap_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL pend_hold got hit=%b kill=%b pc=%h lane=%b op=%b cnt=%0d want 10/00/a0/0/010/1",
               trap_hit, kill_mask, exc_pc, exc_lane, exc_op, trap_cnt);
    end
    idle();
    exc_ack = 1'b1;
    tick();
    n_cmp++;
    if (exc_req !== 1'b0 || exc_pc !== 32'hA0 || trap_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL pend_ack got req=%b pc=%h cnt=%0d want 0/a0/1", exc_req, exc_pc, trap_cnt);
    end
    tick();
    n_cmp++;
    if (exc_req !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_idle got req=%b want 0", exc_req);
    end
    exc_ack = 1'b0;
    set_lane(0, 1, 3'd2, 32'd1, 32'd2, 32'hA0);
    tick();
    set_lane(0, 0, 3'd0, 32'd0, 32'd0, 32'h0);
    set_lane(1, 1, 3'd6, 32'd1, 32'd2, 32'hC4);
    exc_ack = 1'b1;
    tick();
    n_cmp++;
    if (exc_req !== 1'b1 || exc_pc !== 32'hC4 || exc_lane !== 1'b1 || exc_op !== 3'd6 || trap_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL ack_replace got req=%b pc=%h lane=%b op=%b cnt=%0d want 1/c4/1/110/3",
               exc_req, exc_pc, exc_lane, exc_op, trap_cnt);
    end
  endtask

  task automatic test_stall_flush;
    do_reset();
    set_lane(0, 1, 3'd1, 32'd0, 32'd0, 32'h10);
    tick();
    set_lane(0, 0, 3'd0, 32'd0, 32'd0, 32'h0);
    set_lane(1, 1, 3'd1, 32'd9, 32'd9, 32'h14);
    stall = 1'b1;
    tick();
    n_cmp++;
    if (trap_hit !== 2'b01 || kill_mask !== 2'b10 || exc_req !== 1'b1 || exc_pc !== 32'h10 || trap_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL stall_hold got hit=%b kill=%b req=%b pc=%h cnt=%0d want 01/10/1/10/1",
               trap_hit, kill_mask, exc_req, exc_pc, trap_cnt);
    end
    flush = 1'b1;
    tick();
    n_cmp++;
    if (trap_hit !== 2'b00 || kill_mask !== 2'b00 || exc_req !== 1'b1 || exc_pc !== 32'h10 || trap_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL flush got hit=%b kill=%b req=%b pc=%h cnt=%0d want 00/00/1/10/1",
               trap_hit, kill_mask, exc_req, exc_pc, trap_cnt);
    end
    idle();
    exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;
    stall = 1'b1;
    set_lane(1, 1, 3'd1, 32'd9, 32'd9, 32'h14);
    tick();
    n_cmp++;
    if (exc_req !== 1'b0 || trap_cnt !== 16'd1 || trap_hit !== 2'b00) begin
      n_fail++;
      $display("FAIL stall_noload got req=%b cnt=%0d hit=%b want 0/1/00", exc_req, trap_cnt, trap_hit);
    end
  endtask

  task automatic test_saturate;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_lane(0, 1, 3'd1, 32'd4, 32'd4, 32'h300);
      tick();
      n_cmp++;
      if (trap_cnt_s !== ((k < 3) ? 2'(k + 1) : 2'd3) || trap_cnt !== 16'(k + 1)) begin
        n_fail++;
        $display("FAIL sat_cnt%0d got %0d/%0d want %0d/%0d", k, trap_cnt_s, trap_cnt,
                 (k < 3) ? k + 1 : 3, k + 1);
      end
      idle();
      exc_ack = 1'b1;
      tick();
      exc_ack = 1'b0;
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    set_lane(1, 1, 3'd4, 32'd8, 32'd3, 32'h400);
    tick();
    idle();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({trap_hit, kill_mask, exc_req, exc_pc, exc_lane, exc_op, trap_cnt} !== '0) begin
      n_fail++;
      $display("FAIL async_reset got hit=%b req=%b pc=%h lane=%b op=%b cnt=%0d want all 0",
               trap_hit, exc_req, exc_pc, exc_lane, exc_op, trap_cnt);
    end
    #1;
    rst = 1'b0;
    set_lane(1, 1, 3'd4, 32'd8, 32'd3, 32'h400);
    tick();
    n_cmp++;
    if (exc_req !== 1'b1 || exc_pc !== 32'h400 || exc_lane !== 1'b1 || trap_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL post_reset_load got req=%b pc=%h lane=%b cnt=%0d want 1/400/1/1",
               exc_req, exc_pc, exc_lane, trap_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_pending();
    test_stall_flush();
    test_saturate();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
